// File: rtl/gb_trace_buffer.sv
// Instruction trace capture ring for the GameBoy core: ring / fill / PC-trigger capture, frozen ordered readout.
// Optional GB_TRACE_TIMESTAMP_EN prepends a free-running cycle timestamp to every record.
module gb_trace_buffer #(
  parameter int DEPTH = 256,
  parameter int PC_W  = 16,
  parameter int IR_W  = 8,
  parameter int REG_W = 8,
  parameter int TS_W  = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1,
`ifdef GB_TRACE_TIMESTAMP_EN
  localparam int REC_W = TS_W + PC_W + IR_W + 4 + REG_W
`else
  localparam int REC_W = PC_W + IR_W + 4 + REG_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [PC_W-1:0]  trig_pc,
  input  logic [CW-1:0]    trig_post,
  input  logic             smp_valid,
  input  logic [PC_W-1:0]  smp_pc,
  input  logic [IR_W-1:0]  smp_ir,
  input  logic [3:0]       smp_flags,
  input  logic [REG_W-1:0] smp_a,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [REC_W-1:0] rd_data,
  output logic             rd_last,
  output logic [1:0]       state,
  output logic [CW-1:0]    count,
  output logic             triggered,
  output logic             wrapped
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_POST   = 2'd2;
  localparam logic [1:0] S_FROZEN = 2'd3;

  localparam logic [1:0] M_FILL = 2'd1;
  localparam logic [1:0] M_TRIG = 2'd2;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_cfg_check
    $error("gb_trace_buffer: DEPTH must be a power of two >= 4 and TS_W >= 1");
  end

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    post_cnt, rd_remaining;
  logic [REC_W-1:0] wr_rec;

  logic          wr_en, pc_hit, fill_full, post_done, freeze_wr, wrap_nx;
  logic [AW-1:0] wr_ptr_nx;
  logic [CW-1:0] count_nx;

`ifdef GB_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running; arm deliberately leaves it alone so captures can be correlated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts <= '0;
    else      ts <= ts + TS_W'(1);
  end

  assign wr_rec = {ts, smp_pc, smp_ir, smp_flags, smp_a};
`else
  assign wr_rec = {smp_pc, smp_ir, smp_flags, smp_a};
`endif

  // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    wr_en     = ((state == S_RUN) || (state == S_POST)) && smp_valid && !arm && !stop;
    wr_ptr_nx = wr_ptr + AW'(1);
    count_nx  = (count == CW'(DEPTH)) ? count : count + CW'(1);
    pc_hit    = (state == S_RUN) && (mode == M_TRIG) && (smp_pc == trig_pc);
    fill_full = (state == S_RUN) && (mode == M_FILL) && (count_nx == CW'(DEPTH));
    post_done = (state == S_POST) && (post_cnt <= CW'(1));
    freeze_wr = fill_full || (pc_hit && (trig_post == '0)) || post_done;
    // The write that fills a FILL capture ends it; nothing was overwritten, so it is not a wrap.
    wrap_nx   = wrapped || ((wr_ptr == AW'(DEPTH - 1)) && !fill_full);
  end

  // NOTE: trace RAM has no reset; the pointers and count decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_rec;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      post_cnt     <= '0;
      rd_remaining <= '0;
      triggered    <= 1'b0;
      wrapped      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (arm) begin
        state        <= S_RUN;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        post_cnt     <= '0;
        rd_remaining <= '0;
        triggered    <= 1'b0;
        wrapped      <= 1'b0;
      end else begin
        case (state)
          S_RUN, S_POST: begin
            if (stop) begin
              state        <= S_FROZEN;
              rd_ptr       <= wrapped ? wr_ptr : '0;
              rd_remaining <= count;
            end else if (wr_en) begin
              wr_ptr  <= wr_ptr_nx;
              count   <= count_nx;
              wrapped <= wrap_nx;
              if (pc_hit) begin
                triggered <= 1'b1;
                post_cnt  <= trig_post;
              end else if (state == S_POST) begin
                post_cnt <= post_cnt - CW'(1);
              end
              if (freeze_wr) begin
                state        <= S_FROZEN;
                rd_ptr       <= wrap_nx ? wr_ptr_nx : '0;
                rd_remaining <= count_nx;
              end else if (pc_hit) begin
                state <= S_POST;
              end
            end
          end
          S_FROZEN: begin
            if (rd_en && (rd_remaining != '0)) begin
              rd_valid     <= 1'b1;
              rd_data      <= mem[rd_ptr];
              rd_last      <= (rd_remaining == CW'(1));
              rd_ptr       <= rd_ptr + AW'(1);
              rd_remaining <= rd_remaining - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_trace_buffer.sv
// Directed bench for gb_trace_buffer at DEPTH=8: ring, fill, trigger, stop/readout edges and async reset.
// Define GB_TRACE_TIMESTAMP_EN for both files to also check timestamp ordering.
module tb_gb_trace_buffer;
  localparam int DEPTH  = 8;
  localparam int CW     = 4;
  localparam int BASE_W = 36;
`ifdef GB_TRACE_TIMESTAMP_EN
  localparam int REC_W = 16 + BASE_W;
`else
  localparam int REC_W = BASE_W;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             arm = 1'b0, stop = 1'b0, smp_valid = 1'b0, rd_en = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [15:0]      trig_pc = '0, smp_pc = '0;
  logic [CW-1:0]    trig_post = '0;
  logic [7:0]       smp_ir = '0, smp_a = '0;
  logic [3:0]       smp_flags = '0;
  logic             rd_valid, rd_last, triggered, wrapped;
  logic [REC_W-1:0] rd_data;
  logic [1:0]       state;
  logic [CW-1:0]    count;

  int vectors = 0;
  int miscompares = 0;

  logic             got_v [$];
  logic             got_l [$];
  logic [REC_W-1:0] got_d [$];

  gb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode),
    .trig_pc(trig_pc), .trig_post(trig_post), .smp_valid(smp_valid),
    .smp_pc(smp_pc), .smp_ir(smp_ir), .smp_flags(smp_flags), .smp_a(smp_a),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .state(state), .count(count), .triggered(triggered), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BASE_W-1:0] exp_rec(input logic [15:0] pc);
    return {pc, pc[7:0] ^ 8'h5A, pc[3:0], ~pc[7:0]};
  endfunction

  task automatic put_sample(input logic [15:0] pc);
    smp_valid = 1'b1;
    smp_pc    = pc;
    smp_ir    = pc[7:0] ^ 8'h5A;
    smp_flags = pc[3:0];
    smp_a     = ~pc[7:0];
    cyc();
    smp_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m);
    mode = m;
    arm  = 1'b1;
    cyc();
    arm  = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic do_reads(input int n);
    got_v.delete();
    got_l.delete();
    got_d.delete();
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      got_v.push_back(rd_valid);
      got_l.push_back(rd_last);
      got_d.push_back(rd_data);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if ({rd_valid, rd_last, triggered, wrapped} !== 4'b0) begin miscompares++;
      $display("FAIL reset_flags got=%b exp=0000", {rd_valid, rd_last, triggered, wrapped}); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    do_stop();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL idle_stop_state got=%0d exp=0", state); end
    do_reads(1);
    vectors++; if (got_v[0] !== 1'b0) begin miscompares++; $display("FAIL idle_read_valid got=%b exp=0", got_v[0]); end
  endtask

  task automatic test_ring();
    do_arm(2'd0);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL ring_arm_state got=%0d exp=1", state); end
    for (int i = 0; i < 11; i++) put_sample(16'h0100 + 16'(i));
    do_stop();
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL ring_state got=%0d exp=3", state); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ring_count got=%0d exp=8", count); end
    vectors++; if (wrapped !== 1'b1) begin miscompares++; $display("FAIL ring_wrapped got=%b exp=1", wrapped); end
    do_reads(9);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got_v[i] !== 1'b1 || got_d[i][BASE_W-1:0] !== exp_rec(16'h0103 + 16'(i)) || got_l[i] !== (i == 7)) begin
        miscompares++;
        $display("FAIL ring_read[%0d] got v=%b rec=%h last=%b exp v=1 rec=%h last=%b",
                 i, got_v[i], got_d[i][BASE_W-1:0], got_l[i], exp_rec(16'h0103 + 16'(i)), (i == 7));
      end
    end
    vectors++; if (got_v[8] !== 1'b0) begin miscompares++; $display("FAIL ring_read_past_end got=%b exp=0", got_v[8]); end
`ifdef GB_TRACE_TIMESTAMP_EN
    for (int i = 1; i < 8; i++) begin
      vectors++;
      if (got_d[i][REC_W-1 -: 16] <= got_d[i-1][REC_W-1 -: 16]) begin
        miscompares++;
        $display("FAIL ring_ts[%0d] got=%0d exp > %0d", i, got_d[i][REC_W-1 -: 16], got_d[i-1][REC_W-1 -: 16]);
      end
    end
`endif
  endtask

  task automatic test_fill();
    do_arm(2'd1);
    for (int i = 0; i < 10; i++) begin
      put_sample(16'h0200 + 16'(i));
      if (i == 6) begin
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL fill_state_7th got=%0d exp=1", state); end
      end
      if (i == 7) begin
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL fill_state_8th got=%0d exp=3", state); end
      end
    end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_count got=%0d exp=8", count); end
    vectors++; if (wrapped !== 1'b0) begin miscompares++; $display("FAIL fill_wrapped got=%b exp=0", wrapped); end
    do_reads(8);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got_v[i] !== 1'b1 || got_d[i][BASE_W-1 -: 16] !== 16'h0200 + 16'(i) || got_l[i] !== (i == 7)) begin
        miscompares++;
        $display("FAIL fill_read[%0d] got v=%b pc=%h last=%b exp v=1 pc=%h last=%b",
                 i, got_v[i], got_d[i][BASE_W-1 -: 16], got_l[i], 16'h0200 + 16'(i), (i == 7));
      end
    end
  endtask

  task automatic test_trigger();
    trig_pc   = 16'h0150;
    trig_post = 4'd2;
    do_arm(2'd2);
    for (int i = 0; i < 8; i++) begin
      put_sample(16'h0148 + 16'(2 * i));
      if (i == 5) begin
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL trig_post_state got=%0d exp=2", state); end
      end
      if (i == 6) begin
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL trig_frozen_state got=%0d exp=3", state); end
      end
    end
    vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL trig_count got=%0d exp=7", count); end
    vectors++; if (triggered !== 1'b1) begin miscompares++; $display("FAIL trig_triggered got=%b exp=1", triggered); end
    do_reads(7);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (got_v[i] !== 1'b1 || got_d[i][BASE_W-1 -: 16] !== 16'h0148 + 16'(2 * i) || got_l[i] !== (i == 6)) begin
        miscompares++;
        $display("FAIL trig_read[%0d] got v=%b pc=%h last=%b exp v=1 pc=%h last=%b",
                 i, got_v[i], got_d[i][BASE_W-1 -: 16], got_l[i], 16'h0148 + 16'(2 * i), (i == 6));
      end
    end
  endtask

  task automatic test_trig_post_zero();
    trig_pc   = 16'h0302;
    trig_post = 4'd0;
    do_arm(2'd2);
    for (int i = 0; i < 4; i++) begin
      put_sample(16'h0300 + 16'(i));
      if (i == 2) begin
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL post0_state got=%0d exp=3", state); end
      end
    end
    vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL post0_count got=%0d exp=3", count); end
    vectors++; if (triggered !== 1'b1) begin miscompares++; $display("FAIL post0_triggered got=%b exp=1", triggered); end
    do_reads(4);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got_v[i] !== 1'b1 || got_d[i][BASE_W-1 -: 16] !== 16'h0300 + 16'(i)) begin
        miscompares++;
        $display("FAIL post0_read[%0d] got v=%b pc=%h exp v=1 pc=%h", i, got_v[i], got_d[i][BASE_W-1 -: 16], 16'h0300 + 16'(i));
      end
    end
    vectors++; if (got_v[3] !== 1'b0) begin miscompares++; $display("FAIL post0_read_past_end got=%b exp=0", got_v[3]); end
  endtask

  task automatic test_back_to_back();
    do_arm(2'd0);
    for (int i = 0; i < 3; i++) put_sample(16'h0400 + 16'(i));
    smp_valid = 1'b1;
    smp_pc    = 16'h0403;
    do_stop();
    smp_valid = 1'b0;
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL b2b_state got=%0d exp=3", state); end
    vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL b2b_count got=%0d exp=3", count); end
    do_reads(5);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got_v[i] !== (i < 3) || got_l[i] !== (i == 2) ||
          (i < 3 && got_d[i][BASE_W-1 -: 16] !== 16'h0400 + 16'(i))) begin
        miscompares++;
        $display("FAIL b2b_read[%0d] got v=%b last=%b pc=%h exp v=%b last=%b pc=%h",
                 i, got_v[i], got_l[i], got_d[i][BASE_W-1 -: 16], (i < 3), (i == 2), 16'h0400 + 16'(i));
      end
    end
  endtask

  task automatic test_arm_priority();
    smp_valid = 1'b1;
    smp_pc    = 16'h0600;
    stop      = 1'b1;
    do_arm(2'd0);
    stop      = 1'b0;
    smp_valid = 1'b0;
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL armstop_state got=%0d exp=1", state); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL armstop_count got=%0d exp=0", count); end
    put_sample(16'h0601);
    do_stop();
    do_reads(2);
    vectors++;
    if (got_v[0] !== 1'b1 || got_l[0] !== 1'b1 || got_d[0][BASE_W-1 -: 16] !== 16'h0601 || got_v[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL armstop_read got v=%b last=%b pc=%h v2=%b exp v=1 last=1 pc=0601 v2=0",
               got_v[0], got_l[0], got_d[0][BASE_W-1 -: 16], got_v[1]);
    end
  endtask

  task automatic test_reset_mid_post();
    trig_pc   = 16'h0500;
    trig_post = 4'd3;
    do_arm(2'd2);
    put_sample(16'h0500);
    put_sample(16'h0501);
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL rstpost_pre_state got=%0d exp=2", state); end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({state, count, rd_valid, rd_last, triggered, wrapped} !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL rstpost_outputs got state=%0d count=%0d v=%b l=%b t=%b w=%b d=%h exp all 0",
               state, count, rd_valid, rd_last, triggered, wrapped, rd_data);
    end
    rst = 1'b1;
    cyc();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rstpost_idle got=%0d exp=0", state); end
  endtask

  initial begin
    #13 rst = 1'b1;
    cyc();
    test_reset();
    test_ring();
    test_fill();
    test_trigger();
    test_trig_post_zero();
    test_back_to_back();
    test_arm_priority();
    test_reset_mid_post();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
